// File: rtl/jtag_lm32_pkg.sv
// Shared definitions for the LM32 JTAG register arbiter.
package jtag_lm32_pkg;

    // Reserved address that carries no payload in either direction.
    localparam logic [2:0] IDLE_ADDR = 3'b111;

    // One {addr,data} word as moved through the 11-bit data register.
    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    localparam int WORD_W = ADDR_W + DATA_W;

    // Transmit FSM encoding.
    //   state     | meaning
    //   ST_EMPTY  | no payload staged, idle token presented to the scan chain
    //   ST_LOADED | payload staged, waiting for Capture-DR
    //   ST_SENT   | payload captured, waiting for Update-DR to retire it
    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_LOADED = 2'd1,
        ST_SENT   = 2'd2
    } tx_state_t;

endpackage

// File: rtl/jtag_rx_fifo.sv
// Synchronous receive FIFO for host-to-target words; reports dropped pushes.
module jtag_rx_fifo
    import jtag_lm32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [WORD_W-1:0] push_word,
    input  logic              pop,
    output logic [WORD_W-1:0] head_word,
    output logic              not_empty,
    output logic              drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              empty;
    logic              full;
    logic              do_pop;
    logic              do_push;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop    = pop && !empty;
    // A simultaneous pop frees the slot the push lands in.
    assign do_push   = push && (!full || do_pop);
    assign drop      = push && full && !do_pop;
    assign not_empty = !empty;
    assign head_word = mem[rd_ptr[AW-1:0]];

    // Pointer advance on accepted push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_word;
    end

endmodule

// File: rtl/jtag_reg_arb.sv
// Two-requester arbiter and transmit FSM in front of the LM32 JTAG data
// register, plus the receive path into jtag_rx_fifo.
module jtag_reg_arb #(
    parameter int         RX_DEPTH  = 2,
    parameter logic [2:0] IDLE_ADDR = jtag_lm32_pkg::IDLE_ADDR
) (
    input  logic        JTCK,
    input  logic        JRSTN,
    input  logic        CAPTURE,
    input  logic        REG_UPDATE,
    input  logic [7:0]  REG_Q,
    input  logic [2:0]  REG_ADDR_Q,
    output logic [7:0]  REG_D,
    output logic [2:0]  REG_ADDR_D,
    input  logic [1:0]  tx_valid,
    input  logic [15:0] tx_data,
    input  logic [5:0]  tx_addr,
    output logic [1:0]  tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic [2:0]  rx_addr,
    input  logic        rx_ready,
    output logic        rx_overflow,
    input  logic        ovf_clr
);

    import jtag_lm32_pkg::WORD_W;
    import jtag_lm32_pkg::tx_state_t;
    import jtag_lm32_pkg::ST_EMPTY;
    import jtag_lm32_pkg::ST_LOADED;
    import jtag_lm32_pkg::ST_SENT;

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic              rr_ptr;
    logic [1:0]        grant;
    logic [7:0]        stg_data;
    logic [2:0]        stg_addr;
    logic              rx_push;
    logic              rx_drop;
    logic [WORD_W-1:0] rx_head;

    // Round-robin grant, only offered while nothing is staged.
    always_comb begin
        grant = 2'b00;
        if (JRSTN && state == ST_EMPTY) begin
            case (tx_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign tx_ready = grant;

    // Next-state logic; an update in LOADED belongs to a scan that captured
    // the idle token, so it does not retire the staged payload.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY:  if (|grant)     state_nxt = ST_LOADED;
            ST_LOADED: if (CAPTURE)    state_nxt = ST_SENT;
            ST_SENT:   if (REG_UPDATE) state_nxt = ST_EMPTY;
            default:                   state_nxt = ST_EMPTY;
        endcase
    end

    // State register, staging capture and round-robin pointer update.
    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN) begin
            state    <= ST_EMPTY;
            rr_ptr   <= 1'b0;
            stg_data <= 8'h00;
            stg_addr <= IDLE_ADDR;
        end else begin
            state <= state_nxt;
            if (grant[0]) begin
                stg_data <= tx_data[7:0];
                stg_addr <= tx_addr[2:0];
                rr_ptr   <= 1'b1;
            end else if (grant[1]) begin
                stg_data <= tx_data[15:8];
                stg_addr <= tx_addr[5:3];
                rr_ptr   <= 1'b0;
            end
        end
    end

    assign REG_D      = (state == ST_EMPTY) ? 8'h00     : stg_data;
    assign REG_ADDR_D = (state == ST_EMPTY) ? IDLE_ADDR : stg_addr;

    assign rx_push = REG_UPDATE && (REG_ADDR_Q != IDLE_ADDR);

    jtag_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (JTCK),
        .rst_n     (JRSTN),
        .push      (rx_push),
        .push_word ({REG_ADDR_Q, REG_Q}),
        .pop       (rx_ready),
        .head_word (rx_head),
        .not_empty (rx_valid),
        .drop      (rx_drop)
    );

    assign rx_data = rx_head[7:0];
    assign rx_addr = rx_head[10:8];

    // Sticky overflow flag; a drop in the clearing cycle keeps it set.
    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN)       rx_overflow <= 1'b0;
        else if (rx_drop) rx_overflow <= 1'b1;
        else if (ovf_clr) rx_overflow <= 1'b0;
    end

endmodule

// File: tb/tb_jtag_reg_arb.sv
// Directed bench for jtag_reg_arb.
module tb_jtag_reg_arb;

    logic        JTCK;
    logic        JRSTN;
    logic        CAPTURE;
    logic        REG_UPDATE;
    logic [7:0]  REG_Q;
    logic [2:0]  REG_ADDR_Q;
    logic [7:0]  REG_D;
    logic [2:0]  REG_ADDR_D;
    logic [1:0]  tx_valid;
    logic [15:0] tx_data;
    logic [5:0]  tx_addr;
    logic [1:0]  tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [2:0]  rx_addr;
    logic        rx_ready;
    logic        rx_overflow;
    logic        ovf_clr;

    int errors = 0;
    int checks = 0;

    logic [7:0] cap_d;
    logic [2:0] cap_a;
    logic [7:0] first_d;

    jtag_reg_arb #(.RX_DEPTH(2), .IDLE_ADDR(3'b111)) dut (
        .JTCK        (JTCK),
        .JRSTN       (JRSTN),
        .CAPTURE     (CAPTURE),
        .REG_UPDATE  (REG_UPDATE),
        .REG_Q       (REG_Q),
        .REG_ADDR_Q  (REG_ADDR_Q),
        .REG_D       (REG_D),
        .REG_ADDR_D  (REG_ADDR_D),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_addr     (tx_addr),
        .tx_ready    (tx_ready),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_addr     (rx_addr),
        .rx_ready    (rx_ready),
        .rx_overflow (rx_overflow),
        .ovf_clr     (ovf_clr)
    );

    initial JTCK = 1'b0;
    always #5 JTCK = ~JTCK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge JTCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One capture/shift/update pair with an idle-address update.
    task automatic scan(output logic [7:0] d, output logic [2:0] a);
        CAPTURE = 1'b1;
        #1;
        d = REG_D;
        a = REG_ADDR_D;
        tick();
        CAPTURE = 1'b0;
        tick();
        tick();
        REG_UPDATE = 1'b1;
        REG_ADDR_Q = 3'b111;
        tick();
        REG_UPDATE = 1'b0;
    endtask

    initial begin
        JRSTN = 1'b0; CAPTURE = 1'b0; REG_UPDATE = 1'b0;
        REG_Q = 8'h00; REG_ADDR_Q = 3'b111;
        tx_valid = 2'b00; tx_data = 16'h0000; tx_addr = 6'o00;
        rx_ready = 1'b0; ovf_clr = 1'b0;
        tick(); tick();
        chk("rst_reg_d", 16'(REG_D), 16'h00);
        chk("rst_reg_addr_d", 16'(REG_ADDR_D), 16'h7);
        chk("rst_rx_valid", 16'(rx_valid), 16'h0);
        chk("rst_tx_ready", 16'(tx_ready), 16'h0);
        chk("rst_overflow", 16'(rx_overflow), 16'h0);

        // Reset while LOADED discards staging.
        JRSTN = 1'b1;
        tick();
        tx_valid = 2'b01; tx_data = 16'h0055; tx_addr = {3'd0, 3'd5};
        #1 chk("pre_rst_grant", 16'(tx_ready), 16'h1);
        tick();
        tx_valid = 2'b00;
        #1 chk("pre_rst_loaded", 16'(REG_D), 16'h55);
        JRSTN = 1'b0;
        #1 chk("midrst_reg_d", 16'(REG_D), 16'h00);
        tick();
        JRSTN = 1'b1;
        tick(); tick();
        chk("postrst_addr_d", 16'(REG_ADDR_D), 16'h7);
        chk("postrst_reg_d", 16'(REG_D), 16'h00);
        chk("postrst_rx_valid", 16'(rx_valid), 16'h0);
        chk("postrst_overflow", 16'(rx_overflow), 16'h0);
        chk("postrst_no_regrant", 16'(tx_ready), 16'h0);

        // Round robin with both requesters held.
        tx_data = {8'h22, 8'h11}; tx_addr = {3'd2, 3'd1}; tx_valid = 2'b11;
        #1 chk("rr_grant1", 16'(tx_ready), 16'h1);
        tick();
        scan(cap_d, cap_a);
        chk("rr_cap1_d", 16'(cap_d), 16'h11);
        chk("rr_cap1_a", 16'(cap_a), 16'h1);
        #1 chk("rr_grant2", 16'(tx_ready), 16'h2);
        tick();
        scan(cap_d, cap_a);
        chk("rr_cap2_d", 16'(cap_d), 16'h22);
        chk("rr_cap2_a", 16'(cap_a), 16'h2);
        #1 chk("rr_grant3", 16'(tx_ready), 16'h1);
        tick();
        scan(cap_d, cap_a);
        tx_valid = 2'b00;
        chk("rr_cap3_d", 16'(cap_d), 16'h11);

        // Grant and capture in the same cycle; single requester wins despite pointer.
        tx_data = 16'h0033; tx_addr = {3'd0, 3'd3}; tx_valid = 2'b01; CAPTURE = 1'b1;
        #1;
        chk("gc_grant", 16'(tx_ready), 16'h1);
        chk("gc_idle_addr", 16'(REG_ADDR_D), 16'h7);
        chk("gc_idle_data", 16'(REG_D), 16'h00);
        tick();
        tx_valid = 2'b00; CAPTURE = 1'b0;
        tick();
        REG_UPDATE = 1'b1; REG_ADDR_Q = 3'b111;
        tick();
        REG_UPDATE = 1'b0;
        #1 chk("gc_still_loaded", 16'(REG_D), 16'h33);
        scan(cap_d, cap_a);
        chk("gc_payload_d", 16'(cap_d), 16'h33);
        chk("gc_payload_a", 16'(cap_a), 16'h3);
        #1 chk("gc_once", 16'(REG_ADDR_D), 16'h7);

        // Aborted scan: capture, capture, update.
        tx_data = 16'h4400; tx_addr = {3'd4, 3'd0}; tx_valid = 2'b10;
        #1 chk("ab_grant", 16'(tx_ready), 16'h2);
        tick();
        tx_valid = 2'b00;
        CAPTURE = 1'b1;
        #1 first_d = REG_D;
        tick();
        CAPTURE = 1'b0;
        tick();
        tx_valid = 2'b01; CAPTURE = 1'b1;
        #1;
        chk("ab_cap2", 16'(REG_D), 16'h44);
        chk("ab_no_grant_sent", 16'(tx_ready), 16'h0);
        tick();
        CAPTURE = 1'b0;
        tick();
        tx_valid = 2'b00;
        #1;
        chk("ab_cap1", 16'(first_d), 16'h44);
        chk("ab_still_sent", 16'(REG_D), 16'h44);
        REG_UPDATE = 1'b1;
        tick();
        REG_UPDATE = 1'b0;
        #1 chk("ab_empty", 16'(REG_ADDR_D), 16'h7);

        // Fill, overflow, then pop+push while full.
        REG_UPDATE = 1'b1; REG_Q = 8'hA1; REG_ADDR_Q = 3'd0;
        tick();
        REG_Q = 8'hB2; REG_ADDR_Q = 3'd3;
        tick();
        REG_Q = 8'hC3; REG_ADDR_Q = 3'd4;
        tick();
        REG_UPDATE = 1'b0; REG_ADDR_Q = 3'b111;
        #1;
        chk("ovf_set", 16'(rx_overflow), 16'h1);
        chk("ovf_valid", 16'(rx_valid), 16'h1);
        chk("ovf_head_d", 16'(rx_data), 16'hA1);
        chk("ovf_head_a", 16'(rx_addr), 16'h0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        #1 chk("ovf_cleared", 16'(rx_overflow), 16'h0);
        rx_ready = 1'b1; REG_UPDATE = 1'b1; REG_Q = 8'hD4; REG_ADDR_Q = 3'd5;
        tick();
        rx_ready = 1'b0; REG_UPDATE = 1'b0; REG_ADDR_Q = 3'b111;
        #1;
        chk("pp_no_ovf", 16'(rx_overflow), 16'h0);
        chk("pp_head_d", 16'(rx_data), 16'hB2);
        chk("pp_head_a", 16'(rx_addr), 16'h3);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        #1 chk("pp_pushed", 16'({rx_addr, rx_data}), 16'({3'd5, 8'hD4}));

        // Overflow set beats clear in the same cycle.
        REG_UPDATE = 1'b1; REG_Q = 8'hE5; REG_ADDR_Q = 3'd6;
        tick();
        REG_Q = 8'hF6; REG_ADDR_Q = 3'd1; ovf_clr = 1'b1;
        tick();
        REG_UPDATE = 1'b0; REG_ADDR_Q = 3'b111; ovf_clr = 1'b0;
        #1;
        chk("set_wins", 16'(rx_overflow), 16'h1);
        chk("set_wins_head", 16'(rx_data), 16'hD4);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        #1 chk("clr_after", 16'(rx_overflow), 16'h0);

        // Drain, then pop on empty is ignored.
        rx_ready = 1'b1;
        tick();
        #1 chk("drain_second", 16'(rx_data), 16'hE5);
        tick();
        #1 chk("drained", 16'(rx_valid), 16'h0);
        tick();
        rx_ready = 1'b0;
        #1 chk("empty_pop_ignored", 16'(rx_valid), 16'h0);

        // Idle-address update is discarded.
        REG_UPDATE = 1'b1; REG_Q = 8'h99; REG_ADDR_Q = 3'b111;
        tick();
        REG_UPDATE = 1'b0;
        #1;
        chk("idle_upd_valid", 16'(rx_valid), 16'h0);
        chk("idle_upd_ovf", 16'(rx_overflow), 16'h0);

        REG_UPDATE = 1'b1; REG_Q = 8'h5A; REG_ADDR_Q = 3'd2;
        tick();
        REG_UPDATE = 1'b0; REG_ADDR_Q = 3'b111;
        #1 chk("post_empty_push", 16'({7'd0, rx_valid, rx_data}), 16'h015A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jtag_reg_arb.md
JTAG_REG_ARB -- requirements
Module: jtag_reg_arb

Interface
REQ-001 Parameter RX_DEPTH, default 2, receive FIFO depth in entries (power of two, >= 2).
REQ-002 Parameter IDLE_ADDR, default 3'b111, reserved address meaning "no payload".
REQ-003 JTCK  input  1  sole clock; every flop is clocked on its rising edge.
REQ-004 JRSTN  input  1  reset; asynchronous, active-low.
REQ-005 CAPTURE  input  1  one-cycle Capture-DR strobe for the 11-bit LM32 data register (enable & CE & !shift).
REQ-006 REG_UPDATE  input  1  one-cycle Update-DR strobe; REG_Q/REG_ADDR_Q are valid in that cycle.
REQ-007 REG_Q  input  8  host-to-target data byte; REG_ADDR_Q  input  3  host-to-target address.
REQ-008 REG_D  output  8  target-to-host data loaded at capture; REG_ADDR_D  output  3  its address.
REQ-009 tx_valid  input  2  per-requester send request; tx_data  input  16  {req1,req0} bytes; tx_addr  input  6  {req1,req0} addresses.
REQ-010 tx_ready  output  2  per-requester accept strobe, at most one bit high per cycle.
REQ-011 rx_valid  output  1, rx_data  output  8, rx_addr  output  3: receive FIFO head; rx_ready  input  1  pop.
REQ-012 rx_overflow  output  1  sticky drop flag; ovf_clr  input  1  clears it.

Function
REQ-013 Transmit FSM states: EMPTY, LOADED, SENT.
REQ-014 EMPTY: REG_D=8'h00, REG_ADDR_D=IDLE_ADDR.
REQ-015 EMPTY with any tx_valid: grant one requester (round-robin) -> tx_ready for that bit in the same cycle; its data/addr register into staging; next state LOADED.
REQ-016 Round-robin: pointer starts at requester 0; after a grant to n, requester 1-n has priority; with one requester valid, that requester is granted regardless of the pointer.
REQ-017 LOADED: REG_D/REG_ADDR_D drive staging; CAPTURE -> SENT; tx_ready stays 0.
REQ-018 SENT: REG_D/REG_ADDR_D keep staging; REG_UPDATE -> EMPTY; a further CAPTURE without UPDATE (aborted scan) stays in SENT and does not clear staging.
REQ-019 CAPTURE in EMPTY in the same cycle as a grant: capture samples the idle token; the FSM still goes to LOADED, and the payload goes out on the next scan.
REQ-020 Grant-to-REG_D latency is one cycle; no payload is ever lost or duplicated across a full capture/update pair.
REQ-021 Receive: on REG_UPDATE with REG_ADDR_Q != IDLE_ADDR, push {REG_ADDR_Q, REG_Q} into the FIFO; IDLE_ADDR updates are discarded.
REQ-022 FIFO full at push: the word is dropped, rx_overflow=1 from the next cycle, and FIFO contents are unchanged.
REQ-023 A push and a pop (rx_valid & rx_ready) in the same cycle on a full FIFO: the pop frees the slot and the push is accepted, with no overflow.
REQ-024 Pointers have log2(RX_DEPTH)+1 bits and wrap modulo 2*RX_DEPTH; full/empty is decided by pointer MSB compare.
REQ-025 rx_valid = FIFO not empty; head data is combinational from storage; rx_ready while empty is ignored.
REQ-026 ovf_clr in the same cycle as a new overflow: the set wins.

Reset
REQ-027 When JRSTN is low: FSM=EMPTY, RR pointer=0, FIFO empty, rx_overflow=0, tx_ready=0, rx_valid=0, REG_D=8'h00, REG_ADDR_D=IDLE_ADDR.
REQ-028 Reset mid-transfer discards staging and FIFO contents; the requester is not re-granted for the lost word.

Structure
REQ-029 Shared package jtag_lm32_pkg holds IDLE_ADDR, the FSM state encoding, and the 11-bit {addr,data} word width.
REQ-030 One sub-module, jtag_rx_fifo (synchronous FIFO, depth RX_DEPTH, 11 bits wide), is instantiated; the arbiter and FSM sit at top level.

Verification
REQ-031 Reset with JRSTN=0 mid-LOADED -> after release, REG_ADDR_D=3'b111, REG_D=8'h00, rx_valid=0, rx_overflow=0.
REQ-032 Both tx_valid held, req0=(0x11,a=1), req1=(0x22,a=2), three capture/update cycles -> captured sequence 0x11, 0x22, 0x11.
REQ-033 Grant and CAPTURE in the same cycle -> that scan returns addr 3'b111; the next scan returns the payload exactly once.
REQ-034 Capture, capture, update (abort) -> both captures return the same staged byte; the FSM returns to EMPTY only after the update.
REQ-035 Three updates (0xA1,a=0; 0xB2,a=3; 0xC3,a=4) with rx_ready=0 and RX_DEPTH=2 -> FIFO holds A1, B2; rx_overflow=1; then pop+push in the same cycle while full -> accepted, no new overflow.
REQ-036 Update with REG_ADDR_Q=3'b111 -> rx_valid stays 0 and rx_overflow is unchanged.
